fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Three-state instruction fetch unit with branch/jump PC update
//               and a sticky instruction-memory timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    output logic [31:0] pc,
    output logic [31:0] fetch_count,
    output logic        fetch_err
);

    localparam logic [1:0] c_ST_FETCH = 2'd0;
    localparam logic [1:0] c_ST_HOLD  = 2'd1;
    localparam logic [1:0] c_ST_ERROR = 2'd2;

    localparam logic [31:0] c_TIMEOUT = 32'(IMEM_TIMEOUT);

    logic [1:0]  r_state;
    // Only the word index is stored, so the PC can never become misaligned.
    logic [29:0] r_pc_word;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic [31:0] r_wait;

    logic [29:0] w_pc4_word;
    logic [29:0] w_branch_word;
    logic [29:0] w_jump_word;
    logic [29:0] w_next_word;
    logic [31:0] w_wait_inc;

    assign w_pc4_word    = r_pc_word + 30'd1;
    assign w_branch_word = w_pc4_word + {{14{imm16[15]}}, imm16};
    assign w_jump_word   = {w_pc4_word[29:26], addr26};
    assign w_wait_inc    = r_wait + 32'd1;

    always_comb begin
        w_next_word = w_pc4_word;
        if (is_jump) begin
            w_next_word = w_jump_word;
        end else if (is_branch && branch_taken) begin
            w_next_word = w_branch_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_FETCH;
            r_pc_word <= RESET_PC[31:2];
            r_instr   <= 32'd0;
            r_count   <= 32'd0;
            r_wait    <= 32'd0;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_wait  <= 32'd0;
                        r_state <= c_ST_HOLD;
                    end else begin
                        r_wait <= w_wait_inc;
                        if (w_wait_inc >= c_TIMEOUT) begin
                            r_state <= c_ST_ERROR;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (instr_ack) begin
                        r_pc_word <= w_next_word;
                        r_count   <= r_count + 32'd1;
                        r_wait    <= 32'd0;
                        r_state   <= c_ST_FETCH;
                    end
                end
                c_ST_ERROR: begin
                    r_state <= c_ST_ERROR;
                end
                default: begin
                    r_state <= c_ST_ERROR;
                end
            endcase
        end
    end

    assign pc          = {r_pc_word, 2'b00};
    assign imem_addr   = pc;
    assign imem_req    = (r_state == c_ST_FETCH);
    assign instr_valid = (r_state == c_ST_HOLD);
    assign fetch_err   = (r_state == c_ST_ERROR);
    assign instruction = r_instr;
    assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized self-checking bench for fetch_unit against a
//               transaction-level PC/counter model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h1000_0000;
    localparam int          c_TIMEOUT  = 16;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ack;
    logic        is_jump;
    logic        is_branch;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [31:0] pc;
    logic [31:0] fetch_count;
    logic        fetch_err;

    fetch_unit #(
        .RESET_PC     (c_RESET_PC),
        .IMEM_TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_ack    (instr_ack),
        .is_jump      (is_jump),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .addr26       (addr26),
        .pc           (pc),
        .fetch_count  (fetch_count),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc;
    logic [31:0] m_count;

    // Architectural next-PC rule expressed with plain byte arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic j,
                                             input logic b, input logic t,
                                             input logic [15:0] imm, input logic [25:0] a);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        off = int'($signed(imm)) * 4;
        if (j)       return (seq & 32'hF000_0000) | ({6'd0, a} * 32'd4);
        if (b && t)  return seq + 32'(off);
        return seq;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready   = 1'b0;
        imem_rdata   = 32'd0;
        instr_ack    = 1'b0;
        is_jump      = 1'b0;
        is_branch    = 1'b0;
        branch_taken = 1'b0;
        imm16        = 16'd0;
        addr26       = 26'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset   = 1'b0;
        m_pc    = c_RESET_PC;
        m_count = 32'd0;
    endtask

    task automatic deliver(input logic [31:0] w, input int d);
        repeat (d) begin
            imem_ready = 1'b0;
            step();
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        step();
        imem_ready = 1'b0;
    endtask

    task automatic ack_cycle(input logic j, input logic b, input logic t,
                             input logic [15:0] imm, input logic [25:0] a);
        is_jump      = j;
        is_branch    = b;
        branch_taken = t;
        imm16        = imm;
        addr26       = a;
        instr_ack    = 1'b1;
        step();
        idle_inputs();
        m_pc    = ref_next(m_pc, j, b, t, imm, a);
        m_count = m_count + 32'd1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (pc !== c_RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, c_RESET_PC); end
        n_tests++; if (imem_addr !== c_RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, c_RESET_PC); end
        n_tests++; if (instruction !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instruction); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", imem_req); end
        n_tests++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
        // Load a nonzero word, then reset while memory is ready in FETCH.
        deliver(32'hDEAD_BEEF, 0);
        ack_cycle(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        reset      = 1'b0;
        imem_ready = 1'b0;
        m_pc       = c_RESET_PC;
        m_count    = 32'd0;
        n_tests++; if (instruction !== 32'd0) begin n_fail++; $display("FAIL reset_discard_instr: got %h want 0", instruction); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_discard_valid: got %b want 0", instr_valid); end
        n_tests++; if (pc !== c_RESET_PC) begin n_fail++; $display("FAIL reset_discard_pc: got %h want %h", pc, c_RESET_PC); end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ready = 1'b1;
        imem_rdata = 32'h2010_FEFE;
        step();
        imem_ready = 1'b0;
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid: got %b want 1", instr_valid); end
        n_tests++; if (instruction !== 32'h2010_FEFE) begin n_fail++; $display("FAIL seq_instr: got %h want 2010fefe", instruction); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_req_hold: got %b want 0", imem_req); end
        ack_cycle(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        n_tests++; if (pc !== c_RESET_PC + 32'd4) begin n_fail++; $display("FAIL seq_pc: got %h want %h", pc, c_RESET_PC + 32'd4); end
        n_tests++; if (imem_addr !== c_RESET_PC + 32'd4) begin n_fail++; $display("FAIL seq_addr: got %h want %h", imem_addr, c_RESET_PC + 32'd4); end
        n_tests++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL seq_count: got %0d want 1", fetch_count); end
        n_tests++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_refetch: got req=%b valid=%b want req=1 valid=0", imem_req, instr_valid); end
    endtask

    task automatic test_branch();
        deliver(32'h0000_0001, 0);
        ack_cycle(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        deliver(32'h0000_0002, 0);
        ack_cycle(1'b0, 1'b1, 1'b1, 16'hFFFD, 26'd0);
        n_tests++; if (pc !== c_RESET_PC) begin n_fail++; $display("FAIL branch_taken_back: got %h want %h", pc, c_RESET_PC); end
        deliver(32'h0000_0003, 0);
        ack_cycle(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        deliver(32'h0000_0004, 0);
        ack_cycle(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        deliver(32'h0000_0005, 0);
        ack_cycle(1'b0, 1'b1, 1'b0, 16'hFFFD, 26'd0);
        n_tests++; if (pc !== c_RESET_PC + 32'd12) begin n_fail++; $display("FAIL branch_not_taken: got %h want %h", pc, c_RESET_PC + 32'd12); end
        n_tests++; if (fetch_count !== m_count) begin n_fail++; $display("FAIL branch_count: got %0d want %0d", fetch_count, m_count); end
    endtask

    task automatic test_jump();
        deliver(32'h0000_0006, 0);
        ack_cycle(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        n_tests++; if (pc !== 32'h1000_0010) begin n_fail++; $display("FAIL jump_setup_pc: got %h want 10000010", pc); end
        deliver(32'h0800_0040, 0);
        ack_cycle(1'b1, 1'b1, 1'b1, 16'h0010, 26'h000_0040);
        n_tests++; if (pc !== 32'h1000_0100) begin n_fail++; $display("FAIL jump_priority: got %h want 10000100", pc); end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        logic [31:0] pc0;
        int          req_cycles;
        w          = 32'hCAFE_0040;
        pc0        = m_pc;
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req === 1'b1) req_cycles++;
            imem_ready = (i == 5);
            imem_rdata = w;
            step();
        end
        imem_ready = 1'b0;
        // Two extra cycles with no ack: req must have been high exactly six times.
        n_tests++; if (req_cycles != 6) begin n_fail++; $display("FAIL stall_req_cycles: got %0d want 6", req_cycles); end
        for (int i = 0; i < 3; i++) begin
            instr_ack  = 1'b0;
            imem_ready = 1'b1;
            imem_rdata = $urandom;
            step();
            n_tests++; if (instruction !== w || pc !== pc0) begin n_fail++; $display("FAIL stall_stable: got instr=%h pc=%h want instr=%h pc=%h", instruction, pc, w, pc0); end
            n_tests++; if (fetch_count !== m_count || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_count: got cnt=%0d valid=%b want cnt=%0d valid=1", fetch_count, instr_valid, m_count); end
        end
        idle_inputs();
        ack_cycle(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        n_tests++; if (fetch_count !== m_count || pc !== m_pc) begin n_fail++; $display("FAIL stall_ack: got cnt=%0d pc=%h want cnt=%0d pc=%h", fetch_count, pc, m_count, m_pc); end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (c_TIMEOUT - 1) step();
        n_tests++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got req=%b err=%b want req=1 err=0", imem_req, fetch_err); end
        step();
        n_tests++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", fetch_err); end
        n_tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_outputs: got req=%b valid=%b want 0 0", imem_req, instr_valid); end
        instr_ack  = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        repeat (3) step();
        idle_inputs();
        n_tests++; if (fetch_err !== 1'b1 || pc !== c_RESET_PC || fetch_count !== 32'd0) begin n_fail++; $display("FAIL timeout_sticky: got err=%b pc=%h cnt=%0d want err=1 pc=%h cnt=0", fetch_err, pc, fetch_count, c_RESET_PC); end
        n_tests++; if (instruction !== 32'd0) begin n_fail++; $display("FAIL timeout_instr: got %h want 0", instruction); end
        do_reset();
        n_tests++; if (fetch_err !== 1'b0 || pc !== c_RESET_PC || imem_req !== 1'b1) begin n_fail++; $display("FAIL timeout_recover: got err=%b pc=%h req=%b want err=0 pc=%h req=1", fetch_err, pc, imem_req, c_RESET_PC); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            deliver($urandom, 0);
            ack_cycle(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        end
        deliver(32'h0BAD_F00D, 0);
        n_tests++; if (pc !== c_RESET_PC + 32'd20 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got pc=%h valid=%b want pc=%h valid=1", pc, instr_valid, c_RESET_PC + 32'd20); end
        instr_ack = 1'b1;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        idle_inputs();
        m_pc    = c_RESET_PC;
        m_count = 32'd0;
        n_tests++; if (pc !== c_RESET_PC || instr_valid !== 1'b0 || fetch_count !== 32'd0) begin n_fail++; $display("FAIL mid_reset: got pc=%h valid=%b cnt=%0d want pc=%h valid=0 cnt=0", pc, instr_valid, fetch_count, c_RESET_PC); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        j, b, t;
        logic [15:0] imm;
        logic [25:0] a;
        int          d, s;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            d = $urandom_range(0, c_TIMEOUT - 2);
            for (int k = 0; k < d; k++) begin
                imem_ready = 1'b0;
                instr_ack  = 1'($urandom);
                step();
                n_tests++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== m_pc || fetch_count !== m_count) begin n_fail++; $display("FAIL rnd_wait: got req=%b valid=%b addr=%h cnt=%0d want 1 0 %h %0d", imem_req, instr_valid, imem_addr, fetch_count, m_pc, m_count); end
            end
            w          = $urandom;
            imem_ready = 1'b1;
            imem_rdata = w;
            instr_ack  = 1'($urandom);
            step();
            idle_inputs();
            n_tests++; if (instr_valid !== 1'b1 || instruction !== w || pc !== m_pc) begin n_fail++; $display("FAIL rnd_fetch: got valid=%b instr=%h pc=%h want 1 %h %h", instr_valid, instruction, pc, w, m_pc); end
            s = $urandom_range(0, 3);
            for (int k = 0; k < s; k++) begin
                imem_ready = 1'($urandom);
                imem_rdata = $urandom;
                is_jump    = 1'($urandom);
                step();
                n_tests++; if (instr_valid !== 1'b1 || instruction !== w || pc !== m_pc || fetch_count !== m_count) begin n_fail++; $display("FAIL rnd_hold: got instr=%h pc=%h cnt=%0d want %h %h %0d", instruction, pc, fetch_count, w, m_pc, m_count); end
            end
            idle_inputs();
            j   = ($urandom_range(0, 3) == 0);
            b   = 1'($urandom);
            t   = 1'($urandom);
            imm = 16'($urandom);
            a   = 26'($urandom);
            ack_cycle(j, b, t, imm, a);
            n_tests++; if (pc !== m_pc || fetch_count !== m_count || imem_req !== 1'b1) begin n_fail++; $display("FAIL rnd_ack: got pc=%h cnt=%0d req=%b want %h %0d 1 (j=%b b=%b t=%b imm=%h a=%h)", pc, fetch_count, imem_req, m_pc, m_count, j, b, t, imm, a); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
